// File: rtl/add_arbiter_pkg.sv
// add_arbiter_pkg: shared definitions for the round-robin arbitrated adder.
//   - state_e  : controller states (IDLE -> ADD -> RESP)
//   - OPW      : operand width (8)
//   - RESW     : result width including carry-out (9)
//   - wrap_add : modular increment used by the round-robin search
package add_arbiter_pkg;

    localparam int OPW  = 8;
    localparam int RESW = 9;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADD  = 2'd1,
        ST_RESP = 2'd2
    } state_e;

    // (base + inc) mod n, valid for base < n and inc < n
    function automatic int wrap_add(input int base, input int inc, input int n);
        int s;
        s = base + inc;
        if (s >= n) begin
            s = s - n;
        end else begin
            s = s;
        end
        return s;
    endfunction

endpackage

// File: rtl/add_unit.sv
// add_unit: registered 8-bit adder with carry-in, one-cycle latency.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en_i       : load a new result this cycle
//   a_i, b_i   : 8-bit operands
//   cin_i      : carry-in
//   sum_o      : registered {carry, sum}, held while en_i is low
module add_unit
    import add_arbiter_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    input  logic            en_i,
    input  logic [OPW-1:0]  a_i,
    input  logic [OPW-1:0]  b_i,
    input  logic            cin_i,
    output logic [RESW-1:0] sum_o
);

    logic [RESW-1:0] sum_q;

    // Result register: widened add so the carry-out lands in bit 8
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sum_q <= {RESW{1'b0}};
        end else if (en_i) begin
            sum_q <= RESW'(a_i) + RESW'(b_i) + RESW'(cin_i);
        end else begin
            sum_q <= sum_q;
        end
    end

    assign sum_o = sum_q;

endmodule

// File: rtl/add_arbiter.sv
// add_arbiter: NREQ requesters share one registered 8-bit adder. One
// operation is in flight at a time: a round-robin grant in IDLE latches the
// winner's operands, ADD registers the sum, RESP holds the result until the
// consumer accepts it.
// Ports:
//   clk, rst_n           : clock, asynchronous active-low reset
//   req_valid/req_ready  : per-requester handshake (req_ready one-hot)
//   req_a, req_b         : packed 8-bit operands, requester i at [8i+7:8i]
//   req_chain            : (ADD_ARBITER_CARRY_CHAIN_EN only) use the
//                          requester's stored carry as carry-in
//   rsp_valid/rsp_ready  : result handshake
//   rsp_id, rsp_sum      : owner and {carry, sum} of the result
// Configuration macro: ADD_ARBITER_CARRY_CHAIN_EN adds per-requester carry
// registers for multi-byte additions; without it carry-in is always 0.
module add_arbiter
    import add_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2
)(
    input  logic               clk,
    input  logic               rst_n,
    input  logic [NREQ-1:0]    req_valid,
    input  logic [NREQ*OPW-1:0] req_a,
    input  logic [NREQ*OPW-1:0] req_b,
`ifdef ADD_ARBITER_CARRY_CHAIN_EN
    input  logic [NREQ-1:0]    req_chain,
`endif
    output logic [NREQ-1:0]    req_ready,
    output logic               rsp_valid,
    output logic [IDW-1:0]     rsp_id,
    output logic [RESW-1:0]    rsp_sum,
    input  logic               rsp_ready
);

    state_e          state_q;
    logic [IDW-1:0]  ptr_q;
    logic [IDW-1:0]  ptr_d;
    logic [OPW-1:0]  op_a_q;
    logic [OPW-1:0]  op_b_q;
    logic [IDW-1:0]  op_id_q;
    logic            rsp_valid_q;
    logic            cin_s;
    logic            win_found_s;
    logic [IDW-1:0]  win_idx_s;
    logic [IDW-1:0]  cand_s;
    logic            hs_s;

    // Round-robin search: first valid requester at or after ptr_q, wrapping
    always_comb begin
        win_found_s = 1'b0;
        win_idx_s   = {IDW{1'b0}};
        cand_s      = {IDW{1'b0}};
        for (int k = 0; k < NREQ; k++) begin
            cand_s = IDW'(wrap_add(int'(ptr_q), k, NREQ));
            if (!win_found_s && req_valid[cand_s]) begin
                win_found_s = 1'b1;
                win_idx_s   = cand_s;
            end else begin
                win_found_s = win_found_s;
            end
        end
    end

    // Grant is combinational in IDLE; gated by rst_n so reset forces it low
    always_comb begin
        req_ready = {NREQ{1'b0}};
        hs_s      = 1'b0;
        ptr_d     = IDW'(wrap_add(int'(win_idx_s), 1, NREQ));
        if (rst_n && (state_q == ST_IDLE) && win_found_s) begin
            req_ready[win_idx_s] = 1'b1;
            hs_s                 = 1'b1;
        end else begin
            hs_s = 1'b0;
        end
    end

    // Controller: IDLE -> ADD on grant handshake, ADD -> RESP, RESP -> IDLE on accept
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= ST_IDLE;
            ptr_q       <= {IDW{1'b0}};
            op_a_q      <= {OPW{1'b0}};
            op_b_q      <= {OPW{1'b0}};
            op_id_q     <= {IDW{1'b0}};
            rsp_valid_q <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (hs_s) begin
                        op_a_q  <= req_a[int'(win_idx_s)*OPW +: OPW];
                        op_b_q  <= req_b[int'(win_idx_s)*OPW +: OPW];
                        op_id_q <= win_idx_s;
                        ptr_q   <= ptr_d;
                        state_q <= ST_ADD;
                    end else begin
                        state_q <= ST_IDLE;
                    end
                    rsp_valid_q <= 1'b0;
                end
                ST_ADD: begin
                    state_q     <= ST_RESP;
                    rsp_valid_q <= 1'b1;
                end
                ST_RESP: begin
                    if (rsp_ready) begin
                        state_q     <= ST_IDLE;
                        rsp_valid_q <= 1'b0;
                    end else begin
                        state_q     <= ST_RESP;
                        rsp_valid_q <= 1'b1;
                    end
                end
                default: begin
                    state_q     <= ST_IDLE;
                    rsp_valid_q <= 1'b0;
                end
            endcase
        end
    end

`ifdef ADD_ARBITER_CARRY_CHAIN_EN
    logic [NREQ-1:0] carry_q;
    logic            cin_q;

    // Carry-in chosen at grant time; a requester's carry is updated when its result is accepted
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            carry_q <= {NREQ{1'b0}};
            cin_q   <= 1'b0;
        end else begin
            if (hs_s) begin
                cin_q <= req_chain[win_idx_s] & carry_q[win_idx_s];
            end else begin
                cin_q <= cin_q;
            end
            if ((state_q == ST_RESP) && rsp_ready) begin
                carry_q[op_id_q] <= rsp_sum[RESW-1];
            end else begin
                carry_q <= carry_q;
            end
        end
    end

    assign cin_s = cin_q;
`else
    assign cin_s = 1'b0;
`endif

    add_unit u_add_unit (
        .clk   (clk),
        .rst_n (rst_n),
        .en_i  (state_q == ST_ADD),
        .a_i   (op_a_q),
        .b_i   (op_b_q),
        .cin_i (cin_s),
        .sum_o (rsp_sum)
    );

    assign rsp_valid = rsp_valid_q;
    assign rsp_id    = op_id_q;

endmodule

// File: doc/add_arbiter.md
ADD_ARBITER -- requirements
Module: add_arbiter

Interface
REQ-001 Parameter NREQ, default 4, number of requesters sharing the 8-bit adder (2..8).
REQ-002 Parameter IDW, default 2, requester-id width, SHALL equal clog2(NREQ).
REQ-003 clk  input  1  single clock; all state updates on posedge clk.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 req_valid  input  NREQ  per-requester operation request.
REQ-006 req_a  input  NREQ*8  operand A, requester i at bits [8i+7:8i].
REQ-007 req_b  input  NREQ*8  operand B, same packing.
REQ-008 req_ready  output  NREQ  one-hot grant; handshake when req_valid[i]&req_ready[i].
REQ-009 rsp_valid  output  1  result available.
REQ-010 rsp_id  output  IDW  index of requester owning the result.
REQ-011 rsp_sum  output  9  {carry, sum} of the operation.
REQ-012 rsp_ready  input  1  consumer accepts result when rsp_valid&rsp_ready.

Function
REQ-013 One operation in flight at a time; FSM states IDLE, ADD, RESP.
REQ-014 IDLE: if any req_valid, req_ready SHALL be one-hot (combinational) on the round-robin winner; handshake -> ADD; else stay IDLE, req_ready all zero.
REQ-015 Round-robin: search starts at pointer ptr, ascending with wrap NREQ-1 -> 0; on handshake ptr <= winner+1 mod NREQ.
REQ-016 On handshake the winner's operands and id SHALL be latched into operand registers (cycle T).
REQ-017 ADD: adder computes {carry,sum} = a + b + cin registered at T+1; state -> RESP at T+1.
REQ-018 RESP: rsp_valid=1 from cycle T+2; rsp_id, rsp_sum stable until rsp_valid&rsp_ready.
REQ-019 Response handshake -> IDLE; new grant earliest on the following cycle (throughput one op per 3 cycles with rsp_ready held high).
REQ-020 req_ready SHALL be zero in ADD and RESP; requests in those states wait, no drop.
REQ-021 Arithmetic 8+8+1 bits -> 9 bits, no overflow loss; 0xFF+0xFF+1 = 0x1FF.
REQ-022 req_valid deasserted without handshake SHALL have no effect; requester may change operands until handshake.
REQ-023 rsp_ready high in IDLE or ADD SHALL be ignored.

Reset
REQ-024 rst_n low SHALL immediately force: state IDLE, ptr 0, req_ready 0, rsp_valid 0, rsp_id 0, rsp_sum 0, operand registers 0, carry registers 0.
REQ-025 Reset mid-operation SHALL abort it; no response issued for the aborted op.
REQ-026 First grant after rst_n rises SHALL occur no earlier than the first posedge with rst_n high.

Configuration
REQ-027 Macro ADD_ARBITER_CARRY_CHAIN_EN SHALL add input req_chain (NREQ) and a per-requester carry register updated with the carry of each completed op of that requester.
REQ-028 With the macro defined: cin = req_chain[winner] ? carry_reg[winner] : 0, sampled at handshake; enables multi-byte adds per requester.
REQ-029 Without the macro: no req_chain port, no carry registers, cin = 0 always.

Structure
REQ-030 Shared package add_arbiter_pkg SHALL hold the FSM state enum, operand width constant (8) and result width constant (9).
REQ-031 Sub-module add_unit SHALL implement the registered 8-bit adder (a, b, cin -> 9-bit registered result, one-cycle latency, async active-low reset); the round-robin picker stays inline.

Verification
REQ-032 Single request: req_valid=0001, a=0x12, b=0x34 -> grant same cycle, rsp_valid 2 cycles later, rsp_id=0, rsp_sum=0x046.
REQ-033 All four valid continuously, rsp_ready=1 -> grant order 0,1,2,3,0 and one result every 3 cycles.
REQ-034 Requester 2 a=0xFF, b=0x01, rsp_ready low 5 cycles -> rsp_sum=0x100 held stable, req_ready stays 0 until response accepted.
REQ-035 Reset asserted at T+1 of an op -> all outputs 0 asynchronously, no rsp_valid after release, next grant from requester 0.
REQ-036 With ADD_ARBITER_CARRY_CHAIN_EN: requester 1 adds 0xFF+0x01 (rsp 0x100) then 0x00+0x00 with req_chain[1]=1 -> rsp_sum=0x001; with req_chain[1]=0 -> 0x000.
